bcd_serial_adder: RTL and testbench
===================================

# bcd_serial_adder

Multi-digit BCD adder that processes one packed BCD digit per clock, least-significant digit first, using the same per-digit correction rule as the single-digit combinational BCD adder. It sits directly upstream of display and accumulation logic. It accepts two DIGITS-wide packed BCD operands plus a carry-in on a start pulse, iterates digit by digit with an internal carry register, and presents a registered packed BCD sum, carry-out and completion pulse.

## Interface
- DIGITS, 4, number of BCD digits per operand (legal range 2–8)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  request; sampled only when idle
- a  input  4*DIGITS  packed BCD operand A; digit i is at a[4i+3:4i]
- b  input  4*DIGITS  packed BCD operand B, same packing as a
- cin  input  1  carry-in into digit 0
- busy  output  1  high while a request is in progress (state != IDLE)
- done  output  1  one-cycle pulse when sum/cout are valid
- sum  output  4*DIGITS  packed BCD result, registered
- cout  output  1  carry out of the most-significant digit, registered
- invalid  output  1  sticky flag: an operand digit >9 was seen (see Configuration)

## Operation
- States: IDLE, ADD, DONE.
- IDLE, start=1 at a clock edge:
  - latch a, b and cin into internal registers.
  - clear the digit index to 0; load the carry register with cin; clear invalid.
  - go to ADD.
  - sum and cout keep their previous values until overwritten.
- IDLE, start=0: remain in IDLE.
- ADD, each edge, for the current digit index i:
  - s = A_i + B_i + carry, 5 bits wide (range 0–31).
  - If s > 9: sum digit i = (s + 6)[3:0] and new carry = 1.
  - Otherwise: sum digit i = s[3:0] and new carry = 0.
  - Write sum digit i, then i = i + 1.
  - When i == DIGITS-1 is processed, also write cout = new carry and go to DONE.
- DONE: done = 1 for exactly this cycle; next edge returns to IDLE.
- start is ignored while busy, i.e. in ADD and DONE. It is not queued. Operands are taken from the latched copies only, so a and b may change after the start edge.
- Non-BCD input digits follow the same arithmetic, with no saturation. Example: F+F+1 = 31 → digit 5, carry 1.
- Reset (rst_n=0 at an edge) overrides everything, including mid-ADD, and aborts the operation. Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, invalid=0, carry register=0, index=0.

## Timing
- start sampled at edge N → busy high from edge N.
- Digit i is written at edge N+1+i.
- The last digit and cout are written at edge N+DIGITS; done is high between edges N+DIGITS and N+DIGITS+1.
- busy falls at edge N+DIGITS+1, when the state returns to IDLE.
- Start-to-done latency is DIGITS edges. Minimum start-to-start spacing is DIGITS+2 edges: a new start is accepted at the first edge where busy=0.
- sum, cout and invalid are stable and valid from the done cycle until the next accepted start.
- During ADD, sum holds a mix of new and old digits and must not be consumed.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- BCD_SERIAL_CHECK_EN defined:
  - During ADD, invalid is set if A_i > 9 or B_i > 9 for the digit being processed.
  - invalid is sticky until the next accepted start or reset.
  - The sum is still computed by the normal digit rule.
- BCD_SERIAL_CHECK_EN undefined: invalid is tied to 0 and no checking logic is built.

## Test plan
- DIGITS=4, a=16'h1234, b=16'h5678, cin=0, start pulse → done exactly 4 edges after the start edge; sum=16'h6912, cout=0, invalid=0.
- a=16'h9999, b=16'h0000, cin=1 → sum=16'h0000, cout=1. Carry ripples through all digits; busy high for 5 cycles.
- Re-assert start with a=16'h1111, b=16'h1111 during ADD and during DONE → ignored. The result equals the first request, exactly one done pulse is produced, and a start at the first idle edge is accepted.
- rst_n=0 at edge N+2 of a 9999+0001 operation → next cycle state IDLE with busy=0, sum=0, cout=0. No done pulse until a fresh start is accepted.
- BCD_SERIAL_CHECK_EN defined, a=16'h00A0, b=16'h0005 → invalid=1 at done and sum=16'h0105 (digit 1: A+0 = 10 → 0, carry 1). invalid clears on the next accepted start with valid operands. With the macro undefined, the same operands give invalid=0 and the same sum.
- Randomized valid BCD operands, back-to-back requests with start held high → every result matches the decimal sum modulo 10^DIGITS, and cout matches decimal overflow.

Source files
------------

// File: rtl/bcd_serial_if.sv
// Request/result bundle for the digit-serial BCD adder.
// The master drives the request; the slave returns the registered result.
interface bcd_serial_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  invalid;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, invalid
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, invalid
    );
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed BCD adder: one digit per clock, least-significant digit first.
// Optional operand digit checking is enabled by defining BCD_SERIAL_CHECK_EN.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    bcd_serial_if.slave    bus
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = $clog2(DIGITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [W-1:0]    sum_r;
    logic [IW-1:0]   idx_r;
    logic            carry_r;
    logic            cout_r;
    logic            busy_r;
    logic            done_r;
    logic [3:0]      digit_a_s;
    logic [3:0]      digit_b_s;
    logic [3:0]      digit_sum_s;
    logic            carry_s;

    // Single-digit BCD add with +6 correction; returns {carry, digit}.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] x,
                                                 input logic [3:0] y,
                                                 input logic       c);
        logic [4:0] s;
        logic [4:0] t;
        logic [4:0] r;
        s = {1'b0, x} + {1'b0, y} + {4'b0000, c};
        t = s + 5'd6;
        if (s > 5'd9) begin
            r = {1'b1, t[3:0]};
        end else begin
            r = {1'b0, s[3:0]};
        end
        return r;
    endfunction

    // Current-digit datapath from the latched operands.
    always_comb begin
        digit_a_s = a_r[{idx_r, 2'b00} +: 4];
        digit_b_s = b_r[{idx_r, 2'b00} +: 4];
        {carry_s, digit_sum_s} = bcd_digit_add(digit_a_s, digit_b_s, carry_r);
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s = ADD;
                end else begin
                    state_s = IDLE;
                end
            end
            ADD: begin
                if (idx_r == LAST_IDX) begin
                    state_s = DONE;
                end else begin
                    state_s = ADD;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, operand latches and digit-by-digit result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            sum_r   <= {W{1'b0}};
            idx_r   <= {IW{1'b0}};
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        a_r     <= bus.a;
                        b_r     <= bus.b;
                        carry_r <= bus.cin;
                        idx_r   <= {IW{1'b0}};
                    end
                end
                ADD: begin
                    sum_r[{idx_r, 2'b00} +: 4] <= digit_sum_s;
                    carry_r <= carry_s;
                    idx_r   <= idx_r + IW'(1);
                    if (idx_r == LAST_IDX) begin
                        cout_r <= carry_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;

`ifdef BCD_SERIAL_CHECK_EN
    logic invalid_r;

    // Sticky non-BCD operand digit flag, cleared by an accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            invalid_r <= 1'b0;
        end else if ((state_r == IDLE) && bus.start) begin
            invalid_r <= 1'b0;
        end else if ((state_r == ADD) && ((digit_a_s > 4'd9) || (digit_b_s > 4'd9))) begin
            invalid_r <= 1'b1;
        end
    end

    assign bus.invalid = invalid_r;
`else
    assign bus.invalid = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (DIGITS=4): directed cases plus
// randomized back-to-back requests checked against decimal arithmetic.
module tb_bcd_serial_adder;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] got_sum;
    logic        got_cout;
    logic        got_inv;
    int          acc_n, lat, busy_n, done_n;

`ifdef BCD_SERIAL_CHECK_EN
    localparam logic EXP_INV = 1'b1;
`else
    localparam logic EXP_INV = 1'b0;
`endif

    always #5 clk = ~clk;

    bcd_serial_if #(.DIGITS(4)) bus ();

    bcd_serial_adder #(.DIGITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] v);
        int t = 0;
        for (int i = 3; i >= 0; i--) t = t * 10 + int'(v[4*i +: 4]);
        return t;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r = 16'h0000;
        int x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Issue one request, optionally holding start (with junk operands) while busy.
    task automatic op(input logic [15:0] a_v, input logic [15:0] b_v, input logic c_v,
                      input bit hold);
        bit acc = 1'b0;
        int k = 0;
        bus.start = 1'b1; bus.a = a_v; bus.b = b_v; bus.cin = c_v;
        acc_n = 0;
        while (!acc && acc_n < 20) begin
            @(posedge clk); #1;
            acc_n++;
            acc = bus.busy;
        end
        chk("accept", 32'(acc), 32'd1);
        if (!hold) bus.start = 1'b0;
        bus.a = 16'h1111; bus.b = 16'h1111; bus.cin = 1'b0;
        busy_n = 1; done_n = 0; lat = 0;
        while (bus.busy && k < 20) begin
            @(posedge clk); #1;
            k++;
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_n++;
                lat = k;
                got_sum = bus.sum; got_cout = bus.cout; got_inv = bus.invalid;
            end
        end
        chk("busy_drop", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rc;
        int          tot;

        rst_n = 1'b0; bus.start = 1'b0; bus.a = 16'h0; bus.b = 16'h0; bus.cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'h0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_inv", 32'(bus.invalid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op(16'h1234, 16'h5678, 1'b0, 1'b0);
        chk("t1_lat", 32'(lat), 32'd4);
        chk("t1_sum", 32'(got_sum), 32'h6912);
        chk("t1_cout", 32'(got_cout), 32'd0);
        chk("t1_inv", 32'(got_inv), 32'd0);
        chk("t1_hold_sum", 32'(bus.sum), 32'h6912);

        op(16'h9999, 16'h0000, 1'b1, 1'b0);
        chk("t2_sum", 32'(got_sum), 32'h0000);
        chk("t2_cout", 32'(got_cout), 32'd1);
        chk("t2_busy_cycles", 32'(busy_n), 32'd5);

        // start held high through ADD and DONE with 1111 operands
        op(16'h1234, 16'h5678, 1'b0, 1'b1);
        chk("t3_sum", 32'(got_sum), 32'h6912);
        chk("t3_dones", 32'(done_n), 32'd1);
        op(16'h1111, 16'h1111, 1'b0, 1'b0);
        chk("t3_first_idle_accept", 32'(acc_n), 32'd1);
        chk("t3_sum2", 32'(got_sum), 32'h2222);

        // reset during ADD
        bus.start = 1'b1; bus.a = 16'h9999; bus.b = 16'h0001; bus.cin = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("t4_busy", 32'(bus.busy), 32'd0);
        chk("t4_sum", 32'(bus.sum), 32'h0);
        chk("t4_cout", 32'(bus.cout), 32'd0);
        rst_n = 1'b1;
        done_n = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.done) done_n++;
        end
        chk("t4_no_done", 32'(done_n), 32'd0);
        op(16'h9999, 16'h0001, 1'b0, 1'b0);
        chk("t4_fresh_sum", 32'(got_sum), 32'h0000);
        chk("t4_fresh_cout", 32'(got_cout), 32'd1);

        // non-BCD operand digits
        op(16'h00A0, 16'h0005, 1'b0, 1'b0);
        chk("t5_sum", 32'(got_sum), 32'h0105);
        chk("t5_inv", 32'(got_inv), 32'(EXP_INV));
        op(16'h0001, 16'h0002, 1'b0, 1'b0);
        chk("t5_inv_clear", 32'(got_inv), 32'd0);
        chk("t5_sum2", 32'(got_sum), 32'h0003);
        op(16'h000F, 16'h000F, 1'b1, 1'b0);
        chk("t5_ff1_sum", 32'(got_sum), 32'h0015);
        chk("t5_ff1_inv", 32'(got_inv), 32'(EXP_INV));

        // randomized back-to-back requests with start held high
        for (int n = 0; n < 25; n++) begin
            for (int d = 0; d < 4; d++) begin
                ra[4*d +: 4] = 4'($urandom_range(9));
                rb[4*d +: 4] = 4'($urandom_range(9));
            end
            rc = 1'($urandom_range(1));
            tot = bcd2int(ra) + bcd2int(rb) + int'(rc);
            op(ra, rb, rc, 1'b1);
            if (n > 0) chk("rnd_spacing", 32'(acc_n), 32'd1);
            chk("rnd_lat", 32'(lat), 32'd4);
            chk("rnd_sum", 32'(got_sum), 32'(int2bcd(tot % 10000)));
            chk("rnd_cout", 32'(got_cout), 32'(tot >= 10000));
        end
        bus.start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
